// File: rtl/game_select_ctrl.sv
// Game selector: steps through enabled game slots, shows a timed splash of the new
// game number, and routes button pulses only to the active, enabled game.
module game_select_ctrl #(
  parameter int NUM_GAMES     = 4,
  parameter int SEL_W         = 2,
  parameter int NUM_BTNS      = 4,
  parameter int VALUE_W       = 4,
  parameter int SPLASH_CYCLES = 1000000,
  parameter int SPLASH_W      = 24,
  parameter int BLANK_CODE    = 12
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          switch_pulse,
  input  logic [NUM_BTNS-1:0]           btn_pulse,
  input  logic [NUM_GAMES-1:0]          game_en,
  input  logic [NUM_GAMES*VALUE_W-1:0]  game_value,
  output logic [NUM_GAMES*NUM_BTNS-1:0] game_btn,
  output logic [SEL_W-1:0]              game_sel,
  output logic [VALUE_W-1:0]            display_value,
  output logic                          splash_active,
  output logic                          dbg_state
);

  typedef enum logic {S_IDLE, S_SPLASH} state_t;

  localparam logic [SPLASH_W-1:0] SPLASH_LOAD =
    (SPLASH_CYCLES == 0) ? '0 : SPLASH_W'(SPLASH_CYCLES - 1);

  state_t               r_state;
  state_t               w_state_next;
  logic [SEL_W-1:0]     r_game_sel;
  logic [SEL_W-1:0]     w_sel_next;
  logic [SEL_W-1:0]     w_search_sel;
  logic [SPLASH_W-1:0]  r_splash_cnt;
  logic [SPLASH_W-1:0]  w_cnt_next;
  logic                 w_accept;
  logic                 w_sel_en;
  logic [VALUE_W-1:0]   w_sel_value;
  logic                 w_route;

  assign w_accept = switch_pulse & (|game_en);

  // Next enabled slot after the current one: first enabled index above it, otherwise
  // wrap to the lowest enabled index (which is the current slot if it is the only one).
  always_comb begin
    logic [SEL_W-1:0] hi_sel;
    logic [SEL_W-1:0] lo_sel;
    logic             found_hi;
    logic             found_lo;
    hi_sel   = '0;
    lo_sel   = '0;
    found_hi = 1'b0;
    found_lo = 1'b0;
    for (int g = 0; g < NUM_GAMES; g++) begin
      if (game_en[g]) begin
        if (!found_hi && (g > int'(r_game_sel))) begin
          hi_sel   = SEL_W'(g);
          found_hi = 1'b1;
        end
        if (!found_lo) begin
          lo_sel   = SEL_W'(g);
          found_lo = 1'b1;
        end
      end
    end
    if (found_hi)      w_search_sel = hi_sel;
    else if (found_lo) w_search_sel = lo_sel;
    else               w_search_sel = r_game_sel;
  end

  always_comb begin
    w_sel_en    = 1'b0;
    w_sel_value = '0;
    for (int g = 0; g < NUM_GAMES; g++) begin
      if (SEL_W'(g) == r_game_sel) begin
        w_sel_en    = game_en[g];
        w_sel_value = game_value[g*VALUE_W +: VALUE_W];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_game_sel   <= '0;
      r_splash_cnt <= '0;
    end else begin
      r_state      <= w_state_next;
      r_game_sel   <= w_sel_next;
      r_splash_cnt <= w_cnt_next;
    end
  end

  // A switch always wins over the countdown, so a switch during splash reloads it.
  always_comb begin
    w_state_next = r_state;
    w_sel_next   = r_game_sel;
    w_cnt_next   = r_splash_cnt;
    if (w_accept) begin
      w_sel_next = w_search_sel;
      if (SPLASH_CYCLES != 0) begin
        w_state_next = S_SPLASH;
        w_cnt_next   = SPLASH_LOAD;
      end
    end else if (r_state == S_SPLASH) begin
      if (r_splash_cnt == '0) w_state_next = S_IDLE;
      else                    w_cnt_next   = r_splash_cnt - 1'b1;
    end
  end

  assign w_route = (r_state == S_IDLE) & w_sel_en & ~switch_pulse;

  always_comb begin
    game_btn = '0;
    for (int g = 0; g < NUM_GAMES; g++) begin
      if (w_route && (SEL_W'(g) == r_game_sel)) begin
        game_btn[g*NUM_BTNS +: NUM_BTNS] = btn_pulse;
      end
    end
  end

  always_comb begin
    if (r_state == S_SPLASH) display_value = VALUE_W'(r_game_sel);
    else if (w_sel_en)       display_value = w_sel_value;
    else                     display_value = VALUE_W'(BLANK_CODE);
  end

  assign game_sel      = r_game_sel;
  assign splash_active = (r_state == S_SPLASH);
  assign dbg_state     = (r_state == S_SPLASH);

endmodule

// File: tb/tb_game_select_ctrl.sv
// Bench for game_select_ctrl: per-cycle vector table for a 3-cycle splash build, plus
// async reset mid-splash and a splash-disabled build driven with the same stimulus.
module tb_game_select_ctrl;

  localparam int NG = 4;
  localparam int NB = 4;
  localparam int VW = 4;
  localparam int SW = 2;

  typedef struct {
    logic          sw;
    logic [NB-1:0] btn;
    logic [NG-1:0] en;
    logic [SW-1:0] exp_sel;
    logic          exp_act;
    logic [VW-1:0] exp_disp;
    logic [15:0]   exp_btn;
  } vec_t;

  logic             clk;
  logic             reset;
  logic             switch_pulse;
  logic [NB-1:0]    btn_pulse;
  logic [NG-1:0]    game_en;
  logic [NG*VW-1:0] game_value;
  logic [NG*NB-1:0] game_btn;
  logic [SW-1:0]    game_sel;
  logic [VW-1:0]    display_value;
  logic             splash_active;
  logic             dbg_state;
  logic [NG*NB-1:0] z_game_btn;
  logic [SW-1:0]    z_game_sel;
  logic [VW-1:0]    z_display_value;
  logic             z_splash_active;
  logic             z_dbg_state;

  int checks;
  int errors;
  int z_splash_seen;
  vec_t vecs[$];

  game_select_ctrl #(
    .NUM_GAMES(NG), .SEL_W(SW), .NUM_BTNS(NB), .VALUE_W(VW),
    .SPLASH_CYCLES(3), .SPLASH_W(24), .BLANK_CODE(12)
  ) dut (
    .clk(clk), .reset(reset), .switch_pulse(switch_pulse), .btn_pulse(btn_pulse),
    .game_en(game_en), .game_value(game_value), .game_btn(game_btn),
    .game_sel(game_sel), .display_value(display_value),
    .splash_active(splash_active), .dbg_state(dbg_state)
  );

  game_select_ctrl #(
    .NUM_GAMES(NG), .SEL_W(SW), .NUM_BTNS(NB), .VALUE_W(VW),
    .SPLASH_CYCLES(0), .SPLASH_W(24), .BLANK_CODE(12)
  ) dut_nosplash (
    .clk(clk), .reset(reset), .switch_pulse(switch_pulse), .btn_pulse(btn_pulse),
    .game_en(game_en), .game_value(game_value), .game_btn(z_game_btn),
    .game_sel(z_game_sel), .display_value(z_display_value),
    .splash_active(z_splash_active), .dbg_state(z_dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (z_splash_active === 1'b1) z_splash_seen++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic sw, input logic [NB-1:0] btn, input logic [NG-1:0] en,
                     input logic [SW-1:0] sel, input logic act, input logic [VW-1:0] disp,
                     input logic [15:0] gbtn);
    vec_t v;
    v.sw = sw; v.btn = btn; v.en = en; v.exp_sel = sel;
    v.exp_act = act; v.exp_disp = disp; v.exp_btn = gbtn;
    vecs.push_back(v);
  endtask

  task automatic add_n(input int n, input logic [NG-1:0] en, input logic [SW-1:0] sel,
                       input logic act, input logic [VW-1:0] disp);
    for (int i = 0; i < n; i++) add(1'b0, 4'h0, en, sel, act, disp, 16'h0);
  endtask

  // Driver: inputs change at negedge, outputs sampled 1 time unit later (before posedge).
  task automatic drive(input logic sw, input logic [NB-1:0] btn, input logic [NG-1:0] en);
    @(negedge clk);
    switch_pulse = sw;
    btn_pulse    = btn;
    game_en      = en;
    #1;
  endtask

  initial begin
    checks = 0; errors = 0; z_splash_seen = 0;
    reset = 1'b1; switch_pulse = 1'b0; btn_pulse = '0; game_en = 4'hF;
    game_value = 16'h9753;  // g3=9 g2=7 g1=5 g0=3

    // Walk all four games, button routing and dropping
    add(0, 4'h0, 4'hF, 0, 0, 3, 16'h0);
    add(1, 4'h1, 4'hF, 0, 0, 3, 16'h0);
    add(0, 4'h1, 4'hF, 1, 1, 1, 16'h0);
    add_n(2, 4'hF, 1, 1, 1);
    add(0, 4'h2, 4'hF, 1, 0, 5, 16'h0020);
    add(1, 4'h0, 4'hF, 1, 0, 5, 16'h0);
    add(0, 4'h1, 4'hF, 2, 1, 2, 16'h0);
    add_n(2, 4'hF, 2, 1, 2);
    add(0, 4'h1, 4'hF, 2, 0, 7, 16'h0100);
    add(1, 4'h1, 4'hF, 2, 0, 7, 16'h0);
    add(0, 4'h1, 4'hF, 3, 1, 3, 16'h0);
    add_n(2, 4'hF, 3, 1, 3);
    add(0, 4'h8, 4'hF, 3, 0, 9, 16'h8000);
    add(1, 4'h0, 4'hF, 3, 0, 9, 16'h0);
    add_n(3, 4'hF, 0, 1, 0);
    add(0, 4'h1, 4'hF, 0, 0, 3, 16'h0001);
    // Switch during splash restarts it
    add(1, 4'h0, 4'hF, 0, 0, 3, 16'h0);
    add(0, 4'h0, 4'hF, 1, 1, 1, 16'h0);
    add(1, 4'h0, 4'hF, 1, 1, 1, 16'h0);
    add_n(3, 4'hF, 2, 1, 2);
    add(0, 4'h0, 4'hF, 2, 0, 7, 16'h0);
    // Mask 1011: active game disabled, then skipping game 2
    add(0, 4'h1, 4'hB, 2, 0, 12, 16'h0);
    add(1, 4'h0, 4'hB, 2, 0, 12, 16'h0);
    add_n(3, 4'hB, 3, 1, 3);
    add(1, 4'h0, 4'hB, 3, 0, 9, 16'h0);
    add_n(3, 4'hB, 0, 1, 0);
    add(1, 4'h0, 4'hB, 0, 0, 3, 16'h0);
    add_n(3, 4'hB, 1, 1, 1);
    add(1, 4'h0, 4'hB, 1, 0, 5, 16'h0);
    add_n(3, 4'hB, 3, 1, 3);
    add(0, 4'h4, 4'hB, 3, 0, 9, 16'h4000);
    // All disabled, then a single enabled game
    add(0, 4'h1, 4'h0, 3, 0, 12, 16'h0);
    add(1, 4'h1, 4'h0, 3, 0, 12, 16'h0);
    add(0, 4'h0, 4'h0, 3, 0, 12, 16'h0);
    add(1, 4'h0, 4'h4, 3, 0, 12, 16'h0);
    add_n(3, 4'h4, 2, 1, 2);
    add(0, 4'h1, 4'h4, 2, 0, 7, 16'h0100);
    add(1, 4'h0, 4'h4, 2, 0, 7, 16'h0);
    add_n(3, 4'h4, 2, 1, 2);
    add(0, 4'h0, 4'h4, 2, 0, 7, 16'h0);

    // Reset state, checked while reset is held
    #12;
    chk("rst_sel", 32'(game_sel), 0);
    chk("rst_act", 32'(splash_active), 0);
    chk("rst_disp", 32'(display_value), 3);
    chk("rst_btn", 32'(game_btn), 0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].sw, vecs[i].btn, vecs[i].en);
      chk($sformatf("v%0d_sel", i), 32'(game_sel), 32'(vecs[i].exp_sel));
      chk($sformatf("v%0d_act", i), 32'(splash_active), 32'(vecs[i].exp_act));
      chk($sformatf("v%0d_disp", i), 32'(display_value), 32'(vecs[i].exp_disp));
      chk($sformatf("v%0d_btn", i), 32'(game_btn), 32'(vecs[i].exp_btn));
      chk($sformatf("v%0d_zsel", i), 32'(z_game_sel), 32'(vecs[i].exp_sel));
    end

    // Asynchronous reset in the middle of a splash on game 3
    drive(1'b1, 4'h0, 4'hF);
    drive(1'b0, 4'h0, 4'hF);
    chk("pre_rst_sel", 32'(game_sel), 3);
    chk("pre_rst_act", 32'(splash_active), 1);
    drive(1'b0, 4'h0, 4'hF);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_sel", 32'(game_sel), 0);
    chk("async_rst_act", 32'(splash_active), 0);
    chk("async_rst_disp", 32'(display_value), 3);
    chk("async_rst_zsel", 32'(z_game_sel), 0);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 4'h1, 4'hF);
    chk("post_rst_act", 32'(splash_active), 0);
    chk("post_rst_btn", 32'(game_btn), 32'h0001);
    drive(1'b0, 4'h0, 4'hF);
    chk("post_rst_sel", 32'(game_sel), 0);
    chk("post_rst_act2", 32'(splash_active), 0);

    chk("nosplash_never_active", 32'(z_splash_seen), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
